hit_miss_logic: RTL and testbench
=================================

// Module: hit_miss_logic
// PURPOSE
//  Tag-compare stage of the 4-way set-associative cache.
//  Compares the lookup tag against the four stored way tags of the indexed set, qualified by each way's valid bit.
//  Reports hit/miss, the hitting way, and a multi-hit error flag, registered once.
//  Sits between the tag RAM read port and the cache controller FSM.
// PARAMETERS
//  TAG_W   36   tag width in bits
//  WAYS    4    number of ways (fixed at 4; hit_way is 2 bits)
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous active-low reset
//  in_valid    in   1         lookup request valid this cycle
//  tag_addr    in   TAG_W     tag field of the requested address
//  tag_way0    in   TAG_W     stored tag, way 0
//  tag_way1    in   TAG_W     stored tag, way 1
//  tag_way2    in   TAG_W     stored tag, way 2
//  tag_way3    in   TAG_W     stored tag, way 3
//  vbit        in   4         valid bits; vbit[i] qualifies tag_way{i}
//  out_valid   out  1         result valid (in_valid delayed 1 cycle)
//  hit         out  1         1 = some valid way matches tag_addr
//  hit_way     out  2         index of matching way; 0 on miss
//  multi_hit   out  1         >1 valid way matches (tag RAM corruption)
// BEHAVIOUR
//  - Per way: match[i] = vbit[i] & (tag_way{i} == tag_addr), full TAG_W-bit equality.
//  - hit = |match.
//  - hit_way = lowest index i with match[i]=1 (priority 0 > 1 > 2 > 3); 0 if no match.
//  - multi_hit = popcount(match) >= 2.
//  - Invalid way never hits, even if its tag equals tag_addr.
//  - Latency 1: on each rising clk edge:
//      - out_valid <= in_valid.
//      - hit, hit_way, multi_hit <= combinational results when in_valid=1.
//      - When in_valid=0: hit, hit_way and multi_hit are forced to 0.
//  - No handshake/backpressure; one lookup per cycle, full throughput.
//  - Reset (rst_n=0, async): out_valid=0, hit=0, hit_way=0, multi_hit=0 immediately.
//  - Release of reset is synchronous to clk.
//  - All-zero tags are legal: tag_addr=0 with a valid way tag of 0 is a hit.
// CONFIGURATION
//  HIT_MISS_STATS_EN defined:
//   - Adds input stats_clr (1, synchronous clear, highest priority).
//   - Adds outputs hit_cnt (32) and miss_cnt (32).
//   - Each cycle with in_valid=1: hit_cnt += hit result, else miss_cnt += 1.
//   - Both counters saturate at 32'hFFFF_FFFF; reset to 0 on rst_n=0.
//  HIT_MISS_STATS_EN undefined: these ports and counters do not exist; core behaviour is identical.
// TESTING
//  1 tag_addr=36'h0_0000_0400, way2=36'h0_0000_0400, way0=0, way1=36'hC_0000_0000, way3=36'h0_0402_0000, vbit=4'hF, in_valid=1
//      -> next cycle hit=1, hit_way=2, multi_hit=0.
//  2 same as 1 but way2=36'h4 -> hit=0, hit_way=0.
//  3 tag_addr=1, ways={0, 36'hC_0000_0000, 4, 0}, vbit=F -> hit=0.
//    Then way3=1 -> hit=1, hit_way=3.
//  4 tag_addr=0, way0=0 and way3=0, vbit=F -> hit=1, hit_way=0, multi_hit=1.
//    Same stimulus with vbit=4'hE -> hit=1, hit_way=3, multi_hit=0.
//  5 Matching tag with vbit all 0 -> hit=0.
//    Assert rst_n=0 mid-stream -> all outputs 0 with no clock edge.
//  6 With HIT_MISS_STATS_EN: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2.
//    Pulse stats_clr -> both counters 0 on the next edge.

Source files
------------

// File: rtl/hit_miss_logic.sv
// Tag-compare stage of the 4-way set-associative cache: valid-qualified tag match, registered hit/way/multi-hit.
// Optional hit/miss statistics counters are compiled in when HIT_MISS_STATS_EN is defined.
module hit_miss_logic #(
  parameter int TAG_W = 36,
  parameter int WAYS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] tag_addr,
  input  logic [TAG_W-1:0] tag_way0,
  input  logic [TAG_W-1:0] tag_way1,
  input  logic [TAG_W-1:0] tag_way2,
  input  logic [TAG_W-1:0] tag_way3,
  input  logic [3:0]       vbit,
`ifdef HIT_MISS_STATS_EN
  input  logic             stats_clr,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt,
`endif
  output logic             out_valid,
  output logic             hit,
  output logic [1:0]       hit_way,
  output logic             multi_hit
);

  logic [TAG_W-1:0] w_way_tag [WAYS];
  logic [WAYS-1:0]  w_match;
  logic             w_hit;
  logic [1:0]       w_hit_way;
  logic [2:0]       w_match_cnt;
  logic             w_multi_hit;

  logic             r_out_valid;
  logic             r_hit;
  logic [1:0]       r_hit_way;
  logic             r_multi_hit;

  assign w_way_tag[0] = tag_way0;
  assign w_way_tag[1] = tag_way1;
  assign w_way_tag[2] = tag_way2;
  assign w_way_tag[3] = tag_way3;

  // An invalid way never matches, whatever its stored tag holds.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_match
      assign w_match[gi] = vbit[gi] & (w_way_tag[gi] == tag_addr);
    end
  endgenerate

  assign w_hit = |w_match;

  // Scan from the highest way downward so the lowest matching index wins.
  always_comb begin
    w_hit_way = 2'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit_way = 2'(i);
      end
    end
  end

  always_comb begin
    w_match_cnt = 3'd0;
    for (int i = 0; i < WAYS; i++) begin
      w_match_cnt = w_match_cnt + {2'd0, w_match[i]};
    end
  end

  assign w_multi_hit = (w_match_cnt >= 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_way   <= 2'd0;
      r_multi_hit <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_hit       <= w_hit;
        r_hit_way   <= w_hit_way;
        r_multi_hit <= w_multi_hit;
      end else begin
        r_hit       <= 1'b0;
        r_hit_way   <= 2'd0;
        r_multi_hit <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign hit       = r_hit;
  assign hit_way   = r_hit_way;
  assign multi_hit = r_multi_hit;

`ifdef HIT_MISS_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Counters stick at all-ones rather than wrapping; clear beats counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (stats_clr) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (in_valid) begin
      if (w_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) begin
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_hit_miss_logic.sv
// Directed-vector bench for hit_miss_logic; stats checks run when HIT_MISS_STATS_EN is defined.
module tb_hit_miss_logic;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [35:0] tag_addr;
  logic [35:0] tag_way0;
  logic [35:0] tag_way1;
  logic [35:0] tag_way2;
  logic [35:0] tag_way3;
  logic [3:0]  vbit;
  logic        out_valid;
  logic        hit;
  logic [1:0]  hit_way;
  logic        multi_hit;
`ifdef HIT_MISS_STATS_EN
  logic        stats_clr;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_checks;
  int n_errors;

  hit_miss_logic #(.TAG_W(36), .WAYS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .tag_addr  (tag_addr),
    .tag_way0  (tag_way0),
    .tag_way1  (tag_way1),
    .tag_way2  (tag_way2),
    .tag_way3  (tag_way3),
    .vbit      (vbit),
`ifdef HIT_MISS_STATS_EN
    .stats_clr (stats_clr),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .out_valid (out_valid),
    .hit       (hit),
    .hit_way   (hit_way),
    .multi_hit (multi_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, then sample just after the next rising edge.
  task automatic lookup(input logic v, input logic [35:0] a,
                        input logic [35:0] w0, input logic [35:0] w1,
                        input logic [35:0] w2, input logic [35:0] w3,
                        input logic [3:0] vb);
    @(negedge clk);
    in_valid = v;
    tag_addr = a;
    tag_way0 = w0;
    tag_way1 = w1;
    tag_way2 = w2;
    tag_way3 = w3;
    vbit     = vb;
    @(posedge clk);
    #1;
    $display("lookup v=%0b addr=%0h ways=%0h/%0h/%0h/%0h vbit=%0h -> ov=%0b hit=%0b way=%0d mh=%0b",
             v, a, w0, w1, w2, w3, vb, out_valid, hit, hit_way, multi_hit);
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic h,
                            input logic [1:0] w, input logic mh);
    check_val({tag, "_ov"},  {63'd0, out_valid}, {63'd0, ov});
    check_val({tag, "_hit"}, {63'd0, hit},       {63'd0, h});
    check_val({tag, "_way"}, {62'd0, hit_way},   {62'd0, w});
    check_val({tag, "_mh"},  {63'd0, multi_hit}, {63'd0, mh});
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    tag_addr  = '0;
    tag_way0  = '0;
    tag_way1  = '0;
    tag_way2  = '0;
    tag_way3  = '0;
    vbit      = '0;
`ifdef HIT_MISS_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    lookup(1'b1, 36'h0_0000_0400, 36'h0, 36'hC_0000_0000, 36'h0_0000_0400, 36'h0_0402_0000, 4'hF);
    expect_out("t1", 1'b1, 1'b1, 2'd2, 1'b0);
    lookup(1'b1, 36'h0_0000_0400, 36'h0, 36'hC_0000_0000, 36'h4, 36'h0_0402_0000, 4'hF);
    expect_out("t2", 1'b1, 1'b0, 2'd0, 1'b0);
    lookup(1'b1, 36'h1, 36'h0, 36'hC_0000_0000, 36'h4, 36'h0, 4'hF);
    expect_out("t3a", 1'b1, 1'b0, 2'd0, 1'b0);
    lookup(1'b1, 36'h1, 36'h0, 36'hC_0000_0000, 36'h4, 36'h1, 4'hF);
    expect_out("t3b", 1'b1, 1'b1, 2'd3, 1'b0);
    lookup(1'b1, 36'h0, 36'h0, 36'hC_0000_0000, 36'h4, 36'h0, 4'hF);
    expect_out("t4a", 1'b1, 1'b1, 2'd0, 1'b1);
    lookup(1'b1, 36'h0, 36'h0, 36'hC_0000_0000, 36'h4, 36'h0, 4'hE);
    expect_out("t4b", 1'b1, 1'b1, 2'd3, 1'b0);
    lookup(1'b1, 36'h7, 36'h8, 36'h7, 36'h6, 36'hF_0000_0007, 4'hF);
    expect_out("way1", 1'b1, 1'b1, 2'd1, 1'b0);
    lookup(1'b1, 36'hF_FFFF_FFFF, 36'h7_FFFF_FFFF, 36'hF_FFFF_FFFE, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 4'hF);
    expect_out("msb", 1'b1, 1'b1, 2'd2, 1'b1);
    lookup(1'b1, 36'h5, 36'h5, 36'h5, 36'h5, 36'h5, 4'h0);
    expect_out("t5_inv", 1'b1, 1'b0, 2'd0, 1'b0);
    lookup(1'b0, 36'h5, 36'h5, 36'h5, 36'h5, 36'h5, 4'hF);
    expect_out("idle", 1'b0, 1'b0, 2'd0, 1'b0);
    lookup(1'b1, 36'h5, 36'h9, 36'h5, 36'h5, 36'h5, 4'hF);
    expect_out("pre_rst", 1'b1, 1'b1, 2'd1, 1'b1);

    // Asynchronous reset between edges: outputs must clear without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("t5_rst", 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

`ifdef HIT_MISS_STATS_EN
    lookup(1'b1, 36'h3, 36'h3, 36'h0, 36'h0, 36'h0, 4'hF);
    check_val("cnt_after_rst_hit",  {32'd0, hit_cnt},  64'd1);
    check_val("cnt_after_rst_miss", {32'd0, miss_cnt}, 64'd0);
    @(negedge clk);
    stats_clr = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    stats_clr = 1'b0;
    lookup(1'b1, 36'h3, 36'h3, 36'h0, 36'h0, 36'h0, 4'hF);
    lookup(1'b1, 36'h3, 36'h3, 36'h0, 36'h0, 36'h0, 4'h0);
    lookup(1'b1, 36'h3, 36'h0, 36'h3, 36'h0, 36'h0, 4'hF);
    lookup(1'b0, 36'h3, 36'h3, 36'h3, 36'h3, 36'h3, 4'hF);
    lookup(1'b1, 36'h3, 36'h0, 36'h0, 36'h0, 36'h0, 4'hF);
    lookup(1'b1, 36'h3, 36'h0, 36'h0, 36'h3, 36'h3, 4'hF);
    check_val("t6_hit_cnt",  {32'd0, hit_cnt},  64'd3);
    check_val("t6_miss_cnt", {32'd0, miss_cnt}, 64'd2);
    @(negedge clk);
    stats_clr = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    check_val("t6_clr_hit",  {32'd0, hit_cnt},  64'd0);
    check_val("t6_clr_miss", {32'd0, miss_cnt}, 64'd0);
    @(negedge clk);
    stats_clr = 1'b0;
    in_valid  = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
